// File: rtl/mc_cu.sv
// Multi-cycle RV32I control unit: IF/ID/EX/MEM/WB sequencing over one shared memory port.
// Optional build macro MC_CU_ILLEGAL_TRAP_EN: illegal instructions lock the FSM in TRAP.
module mc_cu #(
    parameter int STALL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        inst,
    input  logic               z,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               mdr_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               reg_we,
    output logic [1:0]         wb_sel,
    output logic [3:0]         aluc,
    output logic               aluimm,
    output logic               sext,
    output logic               shift,
`ifdef MC_CU_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_e               state_q, state_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_inst;

    assign op          = inst[6:0];
    assign f3          = inst[14:12];
    assign f7          = inst[31:25];
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    logic       legal;
    logic       is_lw, is_sw, is_br, is_beq, is_jal, is_jalr;
    logic [3:0] d_aluc;
    logic       d_aluimm, d_sext, d_shift;

    always_comb begin
        legal    = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_br    = 1'b0;
        is_beq   = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        d_aluc   = 4'b0000;
        d_aluimm = 1'b0;
        d_sext   = 1'b0;
        d_shift  = 1'b0;
        case (op)
            OP_R: begin
                if (f7 == 7'h00 && f3 != 3'b010 && f3 != 3'b011) begin
                    legal  = 1'b1;
                    d_aluc = {1'b0, f3};
                end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal  = 1'b1;
                    d_aluc = {1'b1, f3};
                end
                d_shift = (f3 == 3'b001) || (f3 == 3'b101);
            end
            OP_I: begin
                case (f3)
                    3'b001:         legal = (f7 == 7'h00);
                    3'b101:         legal = (f7 == 7'h00) || (f7 == 7'h20);
                    3'b010, 3'b011: legal = 1'b0;
                    default:        legal = 1'b1;
                endcase
                d_aluimm = 1'b1;
                d_shift  = (f3 == 3'b001) || (f3 == 3'b101);
                d_sext   = ~d_shift;
                d_aluc   = {(f3 == 3'b101) & f7[5], f3};
            end
            OP_LW: begin
                legal    = (f3 == 3'b010);
                is_lw    = 1'b1;
                d_aluimm = 1'b1;
                d_sext   = 1'b1;
            end
            OP_SW: begin
                legal    = (f3 == 3'b010);
                is_sw    = 1'b1;
                d_aluimm = 1'b1;
                d_sext   = 1'b1;
            end
            OP_BR: begin
                legal  = (f3 == 3'b000) || (f3 == 3'b001);
                is_br  = 1'b1;
                is_beq = (f3 == 3'b000);
                d_sext = 1'b1;
            end
            OP_LUI: begin
                legal    = 1'b1;
                d_aluc   = 4'b0010;
                d_aluimm = 1'b1;
            end
            OP_JAL: begin
                legal  = 1'b1;
                is_jal = 1'b1;
                d_sext = 1'b1;
            end
            OP_JALR: begin
                legal    = (f3 == 3'b000);
                is_jalr  = 1'b1;
                d_aluimm = 1'b1;
                d_sext   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // An illegal word decodes to nothing so no class flag can leak into EX/MEM/WB.
        if (!legal) begin
            is_lw    = 1'b0;
            is_sw    = 1'b0;
            is_br    = 1'b0;
            is_beq   = 1'b0;
            is_jal   = 1'b0;
            is_jalr  = 1'b0;
            d_aluc   = 4'b0000;
            d_aluimm = 1'b0;
            d_sext   = 1'b0;
            d_shift  = 1'b0;
        end
    end

    logic dec_en;

    assign dec_en = !reset && (state_q == S_ID || state_q == S_EX ||
                               state_q == S_MEM || state_q == S_WB);

    always_comb begin
        aluc   = dec_en ? d_aluc   : 4'b0000;
        aluimm = dec_en & d_aluimm;
        sext   = dec_en & d_sext;
        shift  = dec_en & d_shift;
    end

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        iord    = 1'b0;
        ir_we   = 1'b0;
        mdr_we  = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'b00;
        reg_we  = 1'b0;
        wb_sel  = 2'b00;
        unique case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (legal) begin
                    state_d = S_EX;
                end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_we   = 1'b1;
                    state_d = S_IF;
`endif
                end
            end
            S_EX: begin
                if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = ((is_beq & z) | (~is_beq & ~z)) ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = is_lw ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
                pc_we   = 1'b1;
                pc_sel  = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                state_d = S_IF;
            end
`ifdef MC_CU_ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_IF;
        endcase
        // Reset kills every strobe at once, including a request still waiting on memory.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            iord    = 1'b0;
            ir_we   = 1'b0;
            mdr_we  = 1'b0;
            pc_we   = 1'b0;
            pc_sel  = 2'b00;
            reg_we  = 1'b0;
            wb_sel  = 2'b00;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (mem_req && !mem_ready && stall_q != {STALL_W{1'b1}}) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
`ifdef MC_CU_ILLEGAL_TRAP_EN
    assign illegal   = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_cu.sv
// Randomized bench for mc_cu: per-instruction phase lists from a table-driven
// instruction model, random memory waits, per-cycle strobe and stall checks.
module tb_mc_cu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        z = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  state;
    logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we, reg_we;
    logic [1:0]  pc_sel, wb_sel;
    logic [3:0]  aluc;
    logic        aluimm, sext, shift;
    logic [7:0]  stall_cnt;
`ifdef MC_CU_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    mc_cu #(.STALL_W(8)) dut (
        .clock(clock), .reset(reset), .inst(inst), .z(z),
        .mem_ready(mem_ready), .state(state), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .mdr_we(mdr_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .aluc(aluc), .aluimm(aluimm), .sext(sext), .shift(shift),
`ifdef MC_CU_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int stall_m = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_LUI, K_JAL, K_JALR, K_ILL} kind_e;
    typedef struct {
        kind_e      k;
        logic [3:0] aluc;
        logic       aluimm;
        logic       sext;
        logic       shift;
        logic       beq;
    } dec_t;

    function automatic dec_t mk(input kind_e k, input logic [3:0] a,
                                input logic im, input logic se,
                                input logic sh, input logic bq);
        dec_t d;
        d.k = k; d.aluc = a; d.aluimm = im; d.sext = se; d.shift = sh; d.beq = bq;
        return d;
    endfunction

    // Mnemonic table: add 0000 sub 1000 and 0111 or 0110 xor 0100
    // sll 0001 srl 0101 sra 1101 lui 0010; memory/branch/jumps use add.
    function automatic dec_t ref_dec(input logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        dec_t d;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        d = mk(K_ILL, 4'b0000, 0, 0, 0, 0);
        case (op)
            7'b0110011: case ({f7, f3})
                {7'h00, 3'b000}: d = mk(K_R, 4'b0000, 0, 0, 0, 0);
                {7'h20, 3'b000}: d = mk(K_R, 4'b1000, 0, 0, 0, 0);
                {7'h00, 3'b001}: d = mk(K_R, 4'b0001, 0, 0, 1, 0);
                {7'h00, 3'b100}: d = mk(K_R, 4'b0100, 0, 0, 0, 0);
                {7'h00, 3'b101}: d = mk(K_R, 4'b0101, 0, 0, 1, 0);
                {7'h20, 3'b101}: d = mk(K_R, 4'b1101, 0, 0, 1, 0);
                {7'h00, 3'b110}: d = mk(K_R, 4'b0110, 0, 0, 0, 0);
                {7'h00, 3'b111}: d = mk(K_R, 4'b0111, 0, 0, 0, 0);
                default: ;
            endcase
            7'b0010011: case (f3)
                3'b000: d = mk(K_I, 4'b0000, 1, 1, 0, 0);
                3'b100: d = mk(K_I, 4'b0100, 1, 1, 0, 0);
                3'b110: d = mk(K_I, 4'b0110, 1, 1, 0, 0);
                3'b111: d = mk(K_I, 4'b0111, 1, 1, 0, 0);
                3'b001: if (f7 == 7'h00) d = mk(K_I, 4'b0001, 1, 0, 1, 0);
                3'b101: begin
                    if (f7 == 7'h00) d = mk(K_I, 4'b0101, 1, 0, 1, 0);
                    if (f7 == 7'h20) d = mk(K_I, 4'b1101, 1, 0, 1, 0);
                end
                default: ;
            endcase
            7'b0000011: if (f3 == 3'b010) d = mk(K_LW, 4'b0000, 1, 1, 0, 0);
            7'b0100011: if (f3 == 3'b010) d = mk(K_SW, 4'b0000, 1, 1, 0, 0);
            7'b1100011: begin
                if (f3 == 3'b000) d = mk(K_BR, 4'b0000, 0, 1, 0, 1);
                if (f3 == 3'b001) d = mk(K_BR, 4'b0000, 0, 1, 0, 0);
            end
            7'b0110111: d = mk(K_LUI, 4'b0010, 1, 0, 0, 0);
            7'b1101111: d = mk(K_JAL, 4'b0000, 0, 1, 0, 0);
            7'b1100111: if (f3 == 3'b000) d = mk(K_JALR, 4'b0000, 1, 1, 0, 0);
            default: ;
        endcase
        return d;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            z = 1'b1;
            inst = $urandom;
            #1;
            chk("rst_state", state, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_strb", {iord, mem_we, ir_we, mdr_we, pc_we, reg_we}, 0);
            chk("rst_sel", {pc_sel, wb_sel}, 0);
            chk("rst_dec", {aluc, aluimm, sext, shift}, 0);
            chk("rst_stall", stall_cnt, 0);
            @(negedge clock);
        end
        reset = 1'b0;
        stall_m = 0;
    endtask

    // Runs one instruction; if_w/mem_w < 0 pick random waits.
    // abort_at names a memory phase index that is cut short after one wait cycle.
    task automatic run_inst(input logic [31:0] w, input int if_w,
                            input int mem_w, input int abort_at);
        dec_t d;
        int   ph[$];
        int   p, waits;
        logic mem, rdy, taken, lw, sw, ill;
        logic [1:0] e_pcsel, e_wbsel;
        logic e_pcwe;
        d = ref_dec(w);
        lw = (d.k == K_LW); sw = (d.k == K_SW); ill = (d.k == K_ILL);
        ph = {0, 1};
        if (!ill) begin
            ph.push_back(2);
            if (lw) begin ph.push_back(3); ph.push_back(4); end
            else if (sw) ph.push_back(3);
            else if (d.k != K_BR) ph.push_back(4);
        end
        foreach (ph[i]) begin
            p = ph[i];
            mem = (p == 0) || (p == 3);
            waits = 0;
            if (mem) begin
                waits = (p == 0) ? if_w : mem_w;
                if (waits < 0) waits = $urandom_range(0, 2);
                if (i == abort_at) waits = 2;
            end
            for (int c = 0; c <= waits; c++) begin
                if (p == 0 && c == 0) inst = w;
                mem_ready = mem ? (c == waits) : 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
                #1;
                rdy = mem && mem_ready;
                taken = d.beq ? z : !z;
                e_pcwe = (p == 1 && ill) || (p == 2 && d.k == K_BR) ||
                         (p == 3 && sw && rdy) || (p == 4);
`ifdef MC_CU_ILLEGAL_TRAP_EN
                if (p == 1 && ill) e_pcwe = 1'b0;
                chk("illegal", illegal, 0);
`endif
                e_pcsel = 2'b00;
                if (p == 2 && d.k == K_BR && taken) e_pcsel = 2'b01;
                if (p == 4 && d.k == K_JAL) e_pcsel = 2'b01;
                if (p == 4 && d.k == K_JALR) e_pcsel = 2'b10;
                e_wbsel = 2'b00;
                if (p == 4) e_wbsel = lw ? 2'b01 :
                    (d.k == K_JAL || d.k == K_JALR) ? 2'b10 : 2'b00;
                chk("state", state, p);
                chk("mem_req", mem_req, mem);
                chk("iord", iord, p == 3);
                chk("mem_we", mem_we, p == 3 && sw);
                chk("ir_we", ir_we, p == 0 && rdy);
                chk("mdr_we", mdr_we, p == 3 && lw && rdy);
                chk("pc_we", pc_we, e_pcwe);
                chk("pc_sel", pc_sel, e_pcsel);
                chk("reg_we", reg_we, p == 4);
                chk("wb_sel", wb_sel, e_wbsel);
                if (p == 0) chk("dec_if", {aluc, aluimm, sext, shift}, 0);
                else chk("dec", {aluc, aluimm, sext, shift},
                         {d.aluc, d.aluimm, d.sext, d.shift});
                chk("stall", stall_cnt, stall_m);
                if (mem && !mem_ready && stall_m < 255) stall_m++;
                @(negedge clock);
                if (i == abort_at && c == 0) return;
            end
        end
`ifdef MC_CU_ILLEGAL_TRAP_EN
        if (ill) begin
            for (int c = 0; c < 3; c++) begin
                mem_ready = 1'b1;
                z = 1'($urandom_range(0, 1));
                #1;
                chk("trap_state", state, 5);
                chk("trap_ill", illegal, 1);
                chk("trap_strb", {mem_req, iord, mem_we, ir_we, mdr_we,
                                  pc_we, reg_we, pc_sel, wb_sel}, 0);
                @(negedge clock);
            end
            do_reset();
        end
`endif
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom;
        f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 9))
            0: return {f7, r[24:7], 7'b0110011};
            1: return {f7, r[24:7], 7'b0010011};
            2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            4: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
            5: return {r[31:7], 7'b0110111};
            6: return {r[31:7], 7'b1101111};
            7: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
            8: return r;
            default: return {r[31:7], 7'b0010011};
        endcase
    endfunction

    initial begin
        #2 reset = 1'b1;
        @(negedge clock);
        do_reset();
        run_inst(32'h002081B3, 0, 0, -1);
        run_inst(32'h00802283, 0, 2, -1);
        chk("t3_stall", stall_cnt, 2);
        for (int i = 0; i < 6; i++) run_inst(32'h00000863, -1, -1, -1);
        run_inst(32'h000100E7, 0, 0, -1);
        for (int i = 0; i < 250; i++) run_inst(rand_inst(), -1, -1, -1);
        run_inst(32'h00802283, 0, 0, 3);
        do_reset();
        run_inst(32'h002081B3, 0, 0, -1);
        run_inst(32'h002081B3, 300, 0, -1);
        chk("sat_stall", stall_cnt, 255);
        run_inst(32'h002081B3, 2, 0, -1);
        run_inst(32'hFFFFFFFF, 0, 0, -1);
        run_inst(32'h002081B3, 0, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
